// File: rtl/ucie_gb_pkg.sv
// Shared state encoding, sizing helpers and beat layout for the AXI-stream client gearbox.
package ucie_gb_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} gb_state_e;

  localparam int GB_DATA_W  = 256;
  localparam int GB_IF_W    = 64;
  localparam int GB_TUSER_W = 16;

  function automatic int ratio(input int data_w, input int if_w);
    return data_w / if_w;
  endfunction

  function automatic int slice_idx_w(input int data_w, input int if_w);
    return $clog2(ratio(data_w, if_w));
  endfunction

  // Layout at the default widths; the top re-declares the same shape at its own parameters.
  typedef struct packed {
    logic [GB_DATA_W-1:0]   data;
    logic [GB_DATA_W/8-1:0] keep;
    logic [GB_TUSER_W-1:0]  user;
    logic                   last;
  } wide_beat_t;

endpackage

// File: rtl/axis_gb_fifo.sv
// Wide-beat FIFO for the gearbox: the head entry stays resident until all its slices are sent,
// and the entry behind it is exposed so the slicer can switch beats without a bubble.
module axis_gb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next_head,
  output logic             more,
  output logic             in_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, rd_ptr_p1, count;
  logic             empty, full, full_n, ready_en;

  assign wr_ptr_n  = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
  assign rd_ptr_n  = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
  assign rd_ptr_p1 = rd_ptr + (AW+1)'(1);
  assign count     = wr_ptr - rd_ptr;
  assign full_n    = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  assign head      = mem[rd_ptr[AW-1:0]];
  assign next_head = mem[rd_ptr_p1[AW-1:0]];
  assign more      = !empty && (count > (AW+1)'(1));
  // ready_en keeps s_tready low until the first clock after reset release
  assign in_ready  = ready_en && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      empty    <= (wr_ptr_n == rd_ptr_n);
      full     <= full_n;
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/axis_client_gearbox.sv
// Down-sizing gearbox: serialises wide AXI-stream beats into IF_W client slices with sop/eop framing.
// Optional statistics counters are enabled by defining UCIE_GB_STATS_EN.
module axis_client_gearbox
  import ucie_gb_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic [DATA_W/8-1:0]  s_tkeep,
  input  logic [TUSER_W-1:0]   s_tuser,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic [IF_W-1:0]      c_data,
  output logic [IF_W/8-1:0]    c_keep,
  output logic [TUSER_W-1:0]   c_user,
  output logic                 c_valid,
  output logic                 c_sop,
  output logic                 c_eop,
  input  logic                 c_ready,
  output logic                 err_keep
`ifdef UCIE_GB_STATS_EN
  ,
  output logic [31:0]          stat_pkt,
  output logic [31:0]          stat_slice,
  output logic [15:0]          stat_err
`endif
);

  localparam int RATIO  = ratio(DATA_W, IF_W);
  localparam int IDX_W  = slice_idx_w(DATA_W, IF_W);
  localparam int KEEP_W = DATA_W / 8;
  localparam int CK_W   = IF_W / 8;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SERVE = SERVE;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [KEEP_W-1:0]  keep;
    logic [TUSER_W-1:0] user;
    logic               last;
  } beat_t;

  // Final slice index: every slice for a mid-packet beat, else the highest slice carrying bytes.
  function automatic logic [IDX_W-1:0] slice_last(input beat_t b);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(RATIO - 1);
    if (b.last) begin
      idx = '0;
      for (int i = 0; i < RATIO; i++)
        if (b.keep[i*CK_W +: CK_W] != '0) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  beat_t            in_beat, head, next_head, load_beat;
  logic [0:0]       state;
  logic [IDX_W-1:0] idx, last_idx, nidx;
  logic             sop_pend, sop_pend_n;
  logic             push, accept, last_acc, fifo_more, load_new, adv, keep_bad;

  assign in_beat  = {s_tdata, s_tkeep, s_tuser, s_tlast};
  assign push     = s_tvalid && s_tready;
  assign accept   = c_valid && c_ready;
  assign last_acc = accept && (idx == last_idx);
  assign nidx     = idx + IDX_W'(1);
  assign keep_bad = push && !s_tlast && (s_tkeep != '1);

  axis_gb_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_beat),
    .pop       (last_acc),
    .head      (head),
    .next_head (next_head),
    .more      (fifo_more),
    .in_ready  (s_tready)
  );

  always_comb begin
    sop_pend_n = sop_pend;
    if (accept && c_eop)
      sop_pend_n = 1'b1;
    else if (accept && c_sop)
      sop_pend_n = 1'b0;
  end

  // Pick the beat feeding slice 0: the entry behind the head if present, else an arriving beat.
  always_comb begin
    load_new  = 1'b0;
    load_beat = in_beat;
    adv       = 1'b0;
    if (state == ST_IDLE) begin
      load_new = push;
    end else if (last_acc) begin
      if (fifo_more) begin
        load_new  = 1'b1;
        load_beat = next_head;
      end else if (push) begin
        load_new = 1'b1;
      end
    end else if (accept) begin
      adv = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      last_idx <= '0;
      sop_pend <= 1'b1;
      c_valid  <= 1'b0;
      c_data   <= '0;
      c_keep   <= '0;
      c_user   <= '0;
      c_sop    <= 1'b0;
      c_eop    <= 1'b0;
    end else begin
      sop_pend <= sop_pend_n;
      if (load_new) begin
        state    <= ST_SERVE;
        idx      <= '0;
        last_idx <= slice_last(load_beat);
        c_valid  <= 1'b1;
        c_data   <= load_beat.data[IF_W-1:0];
        c_keep   <= load_beat.keep[CK_W-1:0];
        c_user   <= load_beat.user;
        c_sop    <= sop_pend_n;
        c_eop    <= load_beat.last && (slice_last(load_beat) == '0);
      end else if (adv) begin
        idx    <= nidx;
        c_data <= head.data[nidx*IF_W +: IF_W];
        c_keep <= head.keep[nidx*CK_W +: CK_W];
        c_user <= head.user;
        c_sop  <= 1'b0;
        c_eop  <= head.last && (nidx == last_idx);
      end else if (last_acc) begin
        state   <= ST_IDLE;
        c_valid <= 1'b0;
        c_sop   <= 1'b0;
        c_eop   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_keep <= 1'b0;
    else if (keep_bad)
      err_keep <= 1'b1;
  end

`ifdef UCIE_GB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt   <= '0;
      stat_slice <= '0;
      stat_err   <= '0;
    end else begin
      if (accept)
        stat_slice <= stat_slice + 32'd1;
      if (accept && c_eop)
        stat_pkt <= stat_pkt + 32'd1;
      if (keep_bad)
        stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_client_gearbox.sv
// Self-checking bench for axis_client_gearbox: directed vector table, multi-cycle corner sequences
// and randomized traffic scored against a slice-queue reference model.
module tb_axis_client_gearbox;

  localparam int DATA_W  = 256;
  localparam int IF_W    = 64;
  localparam int TUSER_W = 16;
  localparam int DEPTH   = 4;
  localparam int RATIO   = DATA_W / IF_W;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int CK_W    = IF_W / 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   s_tdata = '0;
  logic [KEEP_W-1:0]   s_tkeep = '0;
  logic [TUSER_W-1:0]  s_tuser = '0;
  logic                s_tvalid = 1'b0;
  logic                s_tlast = 1'b0;
  logic                s_tready;
  logic [IF_W-1:0]     c_data;
  logic [CK_W-1:0]     c_keep;
  logic [TUSER_W-1:0]  c_user;
  logic                c_valid, c_sop, c_eop;
  logic                c_ready = 1'b1;
  logic                err_keep;
`ifdef UCIE_GB_STATS_EN
  logic [31:0]         stat_pkt, stat_slice;
  logic [15:0]         stat_err;
`endif

  always #5 clk = ~clk;

  axis_client_gearbox #(
    .DATA_W (DATA_W), .IF_W (IF_W), .TUSER_W (TUSER_W), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .s_tdata (s_tdata), .s_tkeep (s_tkeep), .s_tuser (s_tuser),
    .s_tvalid (s_tvalid), .s_tlast (s_tlast), .s_tready (s_tready),
    .c_data (c_data), .c_keep (c_keep), .c_user (c_user),
    .c_valid (c_valid), .c_sop (c_sop), .c_eop (c_eop), .c_ready (c_ready),
    .err_keep (err_keep)
`ifdef UCIE_GB_STATS_EN
    , .stat_pkt (stat_pkt), .stat_slice (stat_slice), .stat_err (stat_err)
`endif
  );

  typedef struct {
    logic [IF_W-1:0]    data;
    logic [CK_W-1:0]    keep;
    logic [TUSER_W-1:0] user;
    logic               sop;
    logic               eop;
  } slice_t;

  typedef struct {
    logic [KEEP_W-1:0]  keep;
    logic               last;
    int                 n_slices;
    logic               first_sop;
    logic [CK_W-1:0]    last_keep;
    logic               last_eop;
  } vec_t;

  slice_t   exp_q[$];
  slice_t   held_s;
  vec_t     vecs[8];
  int       total = 0;
  int       bad = 0;
  logic     pkt_start = 1'b1;
  logic     model_err = 1'b0;
  int       model_slices = 0;
  int       model_pkts = 0;
  int       obs_count = 0;
  logic     obs_first_sop, obs_last_eop;
  logic [CK_W-1:0] obs_last_keep;
  int       bubbles = 0;
  logic     had_valid = 1'b0;
  logic     gap = 1'b0;
  logic     held = 1'b0;
  logic     in_acc = 1'b0;
  logic     rand_ready = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_of(input int nbytes);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < nbytes; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Reference: a beat of n contiguous bytes yields ceil(n/slice bytes) slices (min 1) when last,
  // otherwise every slice; packets open after a last beat.
  task automatic model_push(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                            input logic [TUSER_W-1:0] u, input logic l);
    int n;
    slice_t s;
    n = RATIO;
    if (l) begin
      n = ($countones(k) + CK_W - 1) / CK_W;
      if (n == 0) n = 1;
    end
    if (!l && k != {KEEP_W{1'b1}}) model_err = 1'b1;
    for (int i = 0; i < n; i++) begin
      s.data = d[i*IF_W +: IF_W];
      s.keep = k[i*CK_W +: CK_W];
      s.user = u;
      s.sop  = (i == 0) && pkt_start;
      s.eop  = l && (i == n - 1);
      exp_q.push_back(s);
    end
    pkt_start = l;
  endtask

  task automatic observe();
    slice_t s;
    if (held) begin
      check_output("stall_ctl", 64'({c_valid, c_keep, c_user, c_sop, c_eop}),
                   64'({1'b1, held_s.keep, held_s.user, held_s.sop, held_s.eop}));
      check_output("stall_data", c_data, held_s.data);
    end
    if (c_valid) begin
      if (had_valid && gap) bubbles++;
      had_valid = 1'b1;
      gap = 1'b0;
    end else if (had_valid) begin
      gap = 1'b1;
    end
    if (c_valid && c_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_slice actual=%0h required=none", c_data);
      end else begin
        s = exp_q.pop_front();
        check_output("slice_data", c_data, s.data);
        check_output("slice_ctl", 64'({c_keep, c_user, c_sop, c_eop}),
                     64'({s.keep, s.user, s.sop, s.eop}));
        model_slices++;
        if (s.eop) model_pkts++;
      end
      if (obs_count == 0) obs_first_sop = c_sop;
      obs_count++;
      obs_last_keep = c_keep;
      obs_last_eop = c_eop;
    end
    held = c_valid && !c_ready;
    held_s.data = c_data;
    held_s.keep = c_keep;
    held_s.user = c_user;
    held_s.sop  = c_sop;
    held_s.eop  = c_eop;
    in_acc = s_tvalid && s_tready;
    if (in_acc) model_push(s_tdata, s_tkeep, s_tuser, s_tlast);
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rand_ready) c_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                                input logic [TUSER_W-1:0] u, input logic l);
    s_tdata = d;
    s_tkeep = k;
    s_tuser = u;
    s_tlast = l;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      cycle();
      if (in_acc) break;
    end
    if (!in_acc) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout actual=0 required=1");
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (c_valid || exp_q.size() != 0); t++) cycle();
    check_output("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic start_count();
    obs_count = 0;
    bubbles = 0;
    had_valid = 1'b0;
    gap = 1'b0;
  endtask

  initial begin
    vecs[0] = '{keep: '1,             last: 1'b1, n_slices: 4, first_sop: 1'b1, last_keep: 8'hFF, last_eop: 1'b1};
    vecs[1] = '{keep: 32'h0000_0FFF,  last: 1'b1, n_slices: 2, first_sop: 1'b1, last_keep: 8'h0F, last_eop: 1'b1};
    vecs[2] = '{keep: 32'h0000_0000,  last: 1'b1, n_slices: 1, first_sop: 1'b1, last_keep: 8'h00, last_eop: 1'b1};
    vecs[3] = '{keep: 32'h0000_00FF,  last: 1'b1, n_slices: 1, first_sop: 1'b1, last_keep: 8'hFF, last_eop: 1'b1};
    vecs[4] = '{keep: 32'h00FF_FFFF,  last: 1'b1, n_slices: 3, first_sop: 1'b1, last_keep: 8'hFF, last_eop: 1'b1};
    vecs[5] = '{keep: 32'h0000_001F,  last: 1'b1, n_slices: 1, first_sop: 1'b1, last_keep: 8'h1F, last_eop: 1'b1};
    vecs[6] = '{keep: '1,             last: 1'b0, n_slices: 4, first_sop: 1'b1, last_keep: 8'hFF, last_eop: 1'b0};
    vecs[7] = '{keep: 32'h0000_FFFF,  last: 1'b1, n_slices: 2, first_sop: 1'b0, last_keep: 8'hFF, last_eop: 1'b1};

    // Reset state while rst_n is held low
    #12;
    check_output("rst_ctl", 64'({c_valid, s_tready, c_sop, c_eop, err_keep}), 64'd0);
    check_output("rst_data", 64'({c_keep, c_user}), 64'd0);
    check_output("rst_cdata", c_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("tready_before_clk", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    check_output("tready_rise", 64'(s_tready), 64'd1);

    // Two-beat packet, full keep: eight back-to-back slices
    start_count();
    s_tdata = rand_data(); s_tkeep = '1; s_tuser = 16'hA1; s_tlast = 1'b0; s_tvalid = 1'b1;
    cycle();
    check_output("latency_valid", 64'({c_valid, c_sop}), 64'b11);
    s_tdata = rand_data(); s_tuser = 16'hA2; s_tlast = 1'b1;
    cycle();
    s_tvalid = 1'b0;
    drain();
    check_output("b2b_slices", 64'(obs_count), 64'd8);
    check_output("b2b_bubbles", 64'(bubbles), 64'd0);
    check_output("b2b_eop", 64'(obs_last_eop), 64'd1);

    for (int v = 0; v < 8; v++) begin
      start_count();
      apply_stimulus(rand_data(), vecs[v].keep, 16'(v + 16'h100), vecs[v].last);
      drain();
      check_output("vec_slices", 64'(obs_count), 64'(vecs[v].n_slices));
      check_output("vec_edges", 64'({obs_first_sop, obs_last_keep, obs_last_eop}),
                   64'({vecs[v].first_sop, vecs[v].last_keep, vecs[v].last_eop}));
    end

    // Backpressure: four beats fill the FIFO, a fifth waits while the client stalls
    c_ready = 1'b0;
    start_count();
    for (int b = 0; b < DEPTH; b++) apply_stimulus(rand_data(), '1, 16'(16'h200 + b), 1'b1);
    check_output("tready_full", 64'(s_tready), 64'd0);
    s_tdata = rand_data(); s_tkeep = '1; s_tuser = 16'h2FF; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cycle();
      check_output("stall_no_push", 64'({in_acc, s_tready}), 64'd0);
    end
    c_ready = 1'b1;
    apply_stimulus(s_tdata, s_tkeep, s_tuser, s_tlast);
    drain();
    check_output("bp_slices", 64'(obs_count), 64'(20));

    // Partial keep on a non-last beat raises a sticky error but still sends every slice
    check_output("err_keep_clear", 64'(err_keep), 64'd0);
    start_count();
    apply_stimulus(rand_data(), 32'h00FF_FFFF, 16'h300, 1'b0);
    drain();
    check_output("err_slices", 64'(obs_count), 64'd4);
    check_output("err_keep_set", 64'(err_keep), 64'd1);
    apply_stimulus(rand_data(), '1, 16'h301, 1'b1);
    drain();
    check_output("err_keep_sticky", 64'(err_keep), 64'd1);

    // Randomized traffic with random client backpressure
    rand_ready = 1'b1;
    for (int b = 0; b < 300; b++) begin
      logic             l;
      logic [KEEP_W-1:0] k;
      l = ($urandom_range(0, 2) == 0) || (b == 299);
      if (l) k = keep_of($urandom_range(0, KEEP_W));
      else if ($urandom_range(0, 7) == 0) k = keep_of($urandom_range(1, KEEP_W - 1));
      else k = '1;
      for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
      apply_stimulus(rand_data(), k, 16'($urandom), l);
    end
    rand_ready = 1'b0;
    c_ready = 1'b1;
    drain();
    check_output("rand_err_keep", 64'(err_keep), 64'(model_err));

    // Reset mid-packet discards everything
    c_ready = 1'b0;
    apply_stimulus(rand_data(), '1, 16'h400, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("midrst_ctl", 64'({c_valid, s_tready, c_sop, c_eop, err_keep}), 64'd0);
    exp_q.delete();
    pkt_start = 1'b1;
    model_err = 1'b0;
    model_slices = 0;
    model_pkts = 0;
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_after", 64'({s_tready, c_valid}), 64'b10);
    c_ready = 1'b1;
    start_count();
    apply_stimulus(rand_data(), 32'h0000_00FF, 16'h401, 1'b1);
    drain();
    check_output("midrst_sop", 64'({obs_first_sop, 8'(obs_count)}), 64'({1'b1, 8'd1}));

    // Three packets of five slices each
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(rand_data(), '1, 16'(16'h500 + p), 1'b0);
      apply_stimulus(rand_data(), 32'h0000_00FF, 16'(16'h510 + p), 1'b1);
    end
    drain();
    check_output("pkt_count_model", 64'(model_pkts), 64'd4);
`ifdef UCIE_GB_STATS_EN
    check_output("stat_pkt", 64'(stat_pkt), 64'(model_pkts));
    check_output("stat_slice", 64'(stat_slice), 64'(model_slices));
    check_output("stat_err", 64'(stat_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
